// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encoding, cycle count and sign helper for div_unit
package div_unit_pkg;

  // One restoring step per bit of the 32-bit dividend.
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Two's complement negate when neg is set. The result is read as unsigned,
  // so 0x8000_0000 maps onto itself and still yields the right magnitude.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   i_rem      partial remainder entering the step (always < i_divisor)
//   i_divisor  divisor magnitude
//   i_bit      next dividend bit, MSB first
//   o_rem      partial remainder leaving the step
//   o_q_bit    quotient bit produced by the step
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q_bit
);

  // The shifted remainder can reach 2*divisor-1, which needs one extra bit.
  // A second extra bit carries the borrow of the trial subtraction.
  logic [DATA_W:0]   w_shifted;
  logic [DATA_W+1:0] w_trial;

  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, i_divisor};
  assign o_q_bit   = ~w_trial[DATA_W+1];

  // Both candidates fit in DATA_W bits: the difference is below the divisor
  // when kept, and the shifted value is below the divisor when restored.
  assign o_rem = o_q_bit ? w_trial[DATA_W-1:0] : w_shifted[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned divider for HI/LO writeback
//
// Ports:
//   i_clk, i_resetn   clock, asynchronous active-low reset
//   i_start           launch request, honoured only in IDLE
//   i_signed_div      1 = DIV (two's complement), 0 = DIVU
//   i_annul           cancel an in-flight divide; dominates i_start
//   i_a, i_b          dividend / divisor, sampled with i_start
//   o_busy            high in RUN and FIX
//   o_done            one-cycle pulse, results valid
//   o_hi_out          remainder
//   o_lo_out          quotient
//   o_div_zero        divisor was zero, valid with o_done
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic              i_signed_div,
  input  logic              i_annul,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi_out,
  output logic [DATA_W-1:0] o_lo_out,
  output logic              o_div_zero
);

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  div_state_t        r_state;
  div_state_t        w_next;
  logic [5:0]        r_cnt;
  logic [DATA_W-1:0] r_rem;
  // Holds the dividend magnitude; quotient bits shift in from the bottom
  // as dividend bits leave from the top.
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_dz;

  logic              w_launch;
  logic              w_b_zero;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_rem_next;
  logic              w_q_bit;

  assign w_launch = (r_state == S_IDLE) && i_start && !i_annul;
  assign w_b_zero = (i_b == '0);
  assign w_a_neg  = i_signed_div && i_a[DATA_W-1];
  assign w_b_neg  = i_signed_div && i_b[DATA_W-1];

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem     (r_rem),
    .i_divisor (r_div),
    .i_bit     (r_quo[DATA_W-1]),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_next = w_b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (i_annul) begin
          w_next = S_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        o_busy = 1'b1;
        w_next = i_annul ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        // The result is already committed, so a late annul cannot retract it.
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= cond_neg(i_a, w_a_neg);
            r_div   <= cond_neg(i_b, w_b_neg);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_b_zero) begin
              r_lo <= '1;
              r_hi <= i_a;
              r_dz <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[DATA_W-2:0], w_q_bit};
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          // Sign correction is folded into the result write so the outputs
          // change exactly on entry to DONE.
          if (!i_annul) begin
            r_lo <= cond_neg(r_quo, r_neg_q);
            r_hi <= cond_neg(r_rem, r_neg_r);
            r_dz <= 1'b0;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign o_hi_out   = r_hi;
  assign o_lo_out   = r_lo;
  assign o_div_zero = r_dz;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_W(32)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_start      (start),
    .i_signed_div (signed_div),
    .i_annul      (annul),
    .i_a          (a),
    .i_b          (b),
    .o_busy       (busy),
    .o_done       (done),
    .o_hi_out     (hi_out),
    .o_lo_out     (lo_out),
    .o_div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; wrapping to 32 bits handles MIN/-1.
  function automatic vec_t model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    vec_t   v;
    longint sx;
    longint sy;
    longint lq;
    longint lr;
    v.sgn = sgn;
    v.va  = x;
    v.vb  = y;
    if (y == 32'd0) begin
      v.lo = 32'hFFFF_FFFF;
      v.hi = x;
      v.dz = 1'b1;
    end else begin
      sx = sgn ? longint'($signed(x)) : longint'({32'h0, x});
      sy = sgn ? longint'($signed(y)) : longint'({32'h0, y});
      lq = sx / sy;
      lr = sx % sy;
      v.lo = lq[31:0];
      v.hi = lr[31:0];
      v.dz = 1'b0;
    end
    return v;
  endfunction

  // Drives a launch sampled at the next rising edge (edge N).
  task automatic launch(input logic sgn, input logic [31:0] la, input logic [31:0] lb);
    @(negedge clk);
    start      = 1'b1;
    signed_div = sgn;
    a          = la;
    b          = lb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle i is the cycle following edge N+i-1; sampled at its falling edge.
  task automatic wait_done(input int from, input logic zero_div, output int cyc, output logic busy_bad);
    cyc      = 0;
    busy_bad = 1'b0;
    for (int i = from; i <= 60; i++) begin
      @(negedge clk);
      if (busy !== (!zero_div && i <= 33)) busy_bad = 1'b1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int   cyc;
    logic bb;
    launch(v.sgn, v.va, v.vb);
    wait_done(1, v.dz, cyc, bb);
    check({tag, " latency"}, 32'(cyc), v.dz ? 32'd1 : 32'd34);
    check({tag, " lo_out"}, lo_out, v.lo);
    check({tag, " hi_out"}, hi_out, v.hi);
    check({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, v.dz});
    check({tag, " busy profile"}, {31'b0, bb}, 32'd0);
    @(negedge clk);
    check({tag, " done pulse width"}, {31'b0, done}, 32'd0);
    check({tag, " lo hold"}, lo_out, v.lo);
  endtask

  vec_t table_v[6];

  initial begin
    int   cyc;
    logic bb;
    vec_t rv;

    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    a          = '0;
    b          = '0;
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset lo_out", lo_out, 32'd0);
    check("reset hi_out", hi_out, 32'd0);
    check("reset div_zero", {31'b0, div_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    table_v[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    table_v[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    table_v[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         1'b0};
    table_v[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    table_v[4] = '{1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    table_v[5] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), table_v[i]);

    // Annul at N+10: idle at N+11, no done, outputs kept; relaunch at N+12.
    launch(1'b0, 32'd1000, 32'd3);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) annul = 1'b1;
    end
    @(negedge clk);
    check("annul busy drop", {31'b0, busy}, 32'd0);
    check("annul no done", {31'b0, done}, 32'd0);
    check("annul lo kept", lo_out, 32'hFFFF_FFFD);
    check("annul hi kept", hi_out, 32'd1);
    annul = 1'b0;
    launch(1'b0, 32'd9, 32'd3);
    wait_done(1, 1'b0, cyc, bb);
    check("post-annul latency", 32'(cyc), 32'd34);
    check("post-annul lo_out", lo_out, 32'd3);
    check("post-annul hi_out", hi_out, 32'd0);

    // Start with annul in IDLE: nothing launches.
    @(negedge clk);
    start = 1'b1;
    annul = 1'b1;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    check("start+annul busy", {31'b0, busy}, 32'd0);
    check("start+annul done", {31'b0, done}, 32'd0);

    // Start while busy is ignored; start during DONE is ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a     = 32'd55;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, 1'b0, cyc, bb);
    check("busy-start latency", 32'(cyc), 32'd34);
    check("busy-start lo_out", lo_out, 32'd14);
    check("busy-start hi_out", hi_out, 32'd2);
    check("busy-start div_zero", {31'b0, div_zero}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done-start no done", {31'b0, done}, 32'd0);
    end
    check("done-start lo kept", lo_out, 32'd14);

    // Annul during DONE does not retract the pulse.
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, 1'b0, cyc, bb);
    annul = 1'b1;
    #1;
    check("annul-in-done done", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul-in-done lo_out", lo_out, 32'hFFFF_FFFD);

    // Reset at N+5 with start held high.
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    b      = 32'd3;
    resetn = 1'b0;
    #1;
    check("midrun reset busy", {31'b0, busy}, 32'd0);
    check("midrun reset done", {31'b0, done}, 32'd0);
    check("midrun reset lo_out", lo_out, 32'd0);
    check("midrun reset hi_out", hi_out, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("reset hold busy", {31'b0, busy}, 32'd0);
    end
    start  = 1'b0;
    resetn = 1'b1;
    run_vec("after reset", model(1'b0, 32'd100, 32'd7));

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      logic        rs;
      logic [31:0] ra;
      logic [31:0] rb;
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      rv = model(rs, ra, rb);
      run_vec($sformatf("rand%0d", i), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
